// File: rtl/mm_task_arbiter.sv
// mm_task_arbiter: shares one Montgomery engine between R requesters.
// Owners are picked round-robin, the engine is started with a one-cycle
// pulse, result words are routed back tagged with the owner index, and the
// task is closed with a done/err pulse. A watchdog bounds the RUN phase.
module mm_task_arbiter #(
  parameter int K       = 128,
  parameter int N       = 32,
  parameter int R       = 4,
  parameter int TIMEOUT = 4096,
  localparam int ID_W   = $clog2(R)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [R-1:0]    req,
  output logic [R-1:0]    gnt,
  output logic [R-1:0]    done,
  output logic            err,
  output logic            eng_task_req,
  input  logic            eng_task_grant,
  input  logic            eng_task_end,
  input  logic [K-1:0]    eng_task_res,
  output logic            res_valid,
  output logic [K-1:0]    res_data,
  output logic [ID_W-1:0] res_id,
  output logic            res_last,
  output logic            busy
);

  localparam int CNT_W = $clog2(N) + 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  // Word count that must carry the end marker for a well-formed task.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);
  // Watchdog value seen on the final permitted RUN cycle.
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [ID_W-1:0]   last_owner_q, last_owner_d;
  logic [R-1:0]      gnt_q, gnt_d;
  logic [R-1:0]      done_q, done_d;
  logic              err_q, err_d;
  logic              eng_req_q, eng_req_d;
  logic              res_valid_q, res_valid_d;
  logic [K-1:0]      res_data_q, res_data_d;
  logic [ID_W-1:0]   res_id_q, res_id_d;
  logic              res_last_q, res_last_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              sticky_q, sticky_d;

  logic              pick_valid_s;
  logic [ID_W-1:0]   pick_id_s;
  logic [ID_W-1:0]   cand_s;
  logic              end_hit_s;

  // Round-robin search over requesters starting just after the previous owner.
  always_comb begin
    pick_valid_s = 1'b0;
    pick_id_s    = '0;
    cand_s       = '0;
    for (int i = 1; i <= R; i++) begin
      cand_s = ID_W'((int'(last_owner_q) + i) % R);
      if (!pick_valid_s && req[cand_s]) begin
        pick_valid_s = 1'b1;
        pick_id_s    = cand_s;
      end else begin
        pick_id_s    = pick_id_s;
      end
    end
  end

  // Next-state and next-output computation for the task FSM.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    gnt_d        = gnt_q;
    done_d       = '0;
    err_d        = 1'b0;
    eng_req_d    = 1'b0;
    res_valid_d  = 1'b0;
    res_data_d   = res_data_q;
    res_id_d     = res_id_q;
    res_last_d   = 1'b0;
    cnt_d        = cnt_q;
    wdog_d       = wdog_q;
    sticky_d     = sticky_q;
    end_hit_s    = eng_task_grant & eng_task_end;

    case (state_q)
      S_IDLE: begin
        if (pick_valid_s) begin
          owner_d   = pick_id_s;
          gnt_d     = R'(1'b1) << pick_id_s;
          eng_req_d = 1'b1;
          state_d   = S_ISSUE;
        end else begin
          gnt_d     = '0;
        end
      end

      S_ISSUE: begin
        cnt_d    = '0;
        wdog_d   = '0;
        sticky_d = 1'b0;
        state_d  = S_RUN;
      end

      S_RUN: begin
        wdog_d = wdog_q + WD_W'(1);
        if (eng_task_grant) begin
          res_valid_d = 1'b1;
          res_data_d  = eng_task_res;
          res_id_d    = owner_q;
          cnt_d       = cnt_q + CNT_W'(1);
        end else begin
          res_valid_d = 1'b0;
        end

        if (end_hit_s) begin
          // Malformed when the end marker is not on word N, or words overflowed.
          res_last_d = 1'b1;
          done_d     = gnt_q;
          err_d      = sticky_q | (cnt_q != LAST_IDX);
          state_d    = S_DONE;
        end else if (wdog_q == WD_LAST) begin
          done_d     = gnt_q;
          err_d      = 1'b1;
          state_d    = S_DONE;
        end else begin
          state_d    = S_RUN;
        end

        // Word N arrived without the end marker: the task is already malformed.
        if (eng_task_grant && !eng_task_end && (cnt_q == LAST_IDX)) begin
          sticky_d = 1'b1;
        end else begin
          sticky_d = sticky_q;
        end
      end

      S_DONE: begin
        last_owner_d = owner_q;
        gnt_d        = '0;
        state_d      = S_IDLE;
      end

      default: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // FSM state and all registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      owner_q      <= '0;
      last_owner_q <= ID_W'(R - 1);
      gnt_q        <= '0;
      done_q       <= '0;
      err_q        <= 1'b0;
      eng_req_q    <= 1'b0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_id_q     <= '0;
      res_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      cnt_q        <= '0;
      wdog_q       <= '0;
      sticky_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      err_q        <= err_d;
      eng_req_q    <= eng_req_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_id_q     <= res_id_d;
      res_last_q   <= res_last_d;
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
      wdog_q       <= wdog_d;
      sticky_q     <= sticky_d;
    end
  end

  assign gnt          = gnt_q;
  assign done         = done_q;
  assign err          = err_q;
  assign eng_task_req = eng_req_q;
  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;
  assign res_id       = res_id_q;
  assign res_last     = res_last_q;
  assign busy         = busy_q;

endmodule

// File: doc/mm_task_arbiter.md
MM_TASK_ARBITER -- requirements
Module: mm_task_arbiter

Interface
REQ-001 SHALL have parameter K, default 128, meaning result word width in bits.
REQ-002 SHALL have parameter N, default 32, meaning result words per task.
REQ-003 SHALL have parameter R, default 4, meaning number of requesters (R>=2); ID_W=$clog2(R).
REQ-004 SHALL have parameter TIMEOUT, default 4096, meaning max RUN cycles before abort.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on posedge clk.
REQ-006 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-007 SHALL have port req, input, R, per-requester level task request.
REQ-008 SHALL have port gnt, output, R, one-hot owner of the engine; 0 when free.
REQ-009 SHALL have port done, output, R, one-cycle completion pulse to the owner.
REQ-010 SHALL have port err, output, 1, valid with done: task aborted or malformed.
REQ-011 SHALL have port eng_task_req, output, 1, one-cycle start pulse to the Montgomery engine.
REQ-012 SHALL have port eng_task_grant, input, 1, engine result word valid.
REQ-013 SHALL have port eng_task_end, input, 1, engine last-word marker, qualified by eng_task_grant.
REQ-014 SHALL have port eng_task_res, input, K, engine result word.
REQ-015 SHALL have port res_valid, output, 1, routed result word valid.
REQ-016 SHALL have port res_data, output, K, routed result word.
REQ-017 SHALL have port res_id, output, ID_W, index of requester owning res_data.
REQ-018 SHALL have port res_last, output, 1, marks final routed word.
REQ-019 SHALL have port busy, output, 1, high in any state except IDLE.

Function
REQ-020 SHALL implement FSM states IDLE, ISSUE, RUN, DONE.
REQ-021 IDLE: when req!=0, SHALL select owner round-robin, searching from (last_owner+1) mod R upward, register it, drive gnt, go ISSUE; last_owner resets to R-1 so requester 0 wins first.
REQ-022 ISSUE: SHALL assert eng_task_req for exactly one cycle, clear word counter and watchdog, go RUN.
REQ-023 RUN: on each eng_task_grant=1 cycle, SHALL register res_data=eng_task_res, res_id=owner, res_valid=1 on the next cycle (latency 1), and increment word counter (width $clog2(N)+1).
REQ-024 RUN: eng_task_grant=1 with eng_task_end=1 SHALL set res_last on that word and go DONE; err=1 if word counter before increment != N-1.
REQ-025 RUN: eng_task_end while eng_task_grant=0 SHALL be ignored.
REQ-026 RUN: word counter reaching N without eng_task_end SHALL set err sticky for the task; further words still forwarded.
REQ-027 RUN: watchdog counts RUN cycles; at TIMEOUT cycles without end SHALL go DONE with err=1, res_last not asserted.
REQ-028 DONE: SHALL pulse done[owner]=1 for one cycle with err, update last_owner=owner, clear gnt, go IDLE; the next grant occurs no earlier than the cycle after DONE.
REQ-029 A requester dropping req after grant SHALL NOT abort the task; done and results still delivered.
REQ-030 req changes while busy SHALL NOT change gnt.
REQ-031 gnt SHALL be one-hot or zero at all times; at most one done bit set per cycle.
REQ-032 eng_task_grant outside RUN SHALL be ignored (no res_valid).

Reset
REQ-033 When rst_n=0 at posedge clk, SHALL enter IDLE and drive gnt=0, done=0, err=0, eng_task_req=0, res_valid=0, res_last=0, res_data=0, res_id=0, busy=0, counters=0, last_owner=R-1.
REQ-034 Reset mid-RUN SHALL abandon the task with no done pulse; first grant after reset follows REQ-021.

Verification (N=4, R=4, TIMEOUT=64)
REQ-035 req=4'b0001, engine returns 4 words 0xA..0xD, end on 4th -> one eng_task_req pulse, res_valid 4 cycles with res_id=0, res_last on 0xD, done=4'b0001, err=0.
REQ-036 req=4'b1111 held for 4 tasks -> gnt order 0001,0010,0100,1000, then 0001 again.
REQ-037 eng_task_end on 2nd word -> done pulse with err=1, res_last on word 2, FSM back to IDLE.
REQ-038 engine silent after eng_task_req -> done with err=1 exactly 64 cycles after entering RUN, no res_valid.
REQ-039 rst_n=0 during RUN after 2 words -> all outputs zero next cycle, no done; with req=4'b0100 after release, gnt=4'b0100.
REQ-040 req[1] deasserted 1 cycle after grant -> task completes, 4 words with res_id=1, done[1]=1.
